dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory subsystem for the single-cycle MIPS core. It consumes the core's data-bus outputs (address, write data, write strobe, byte/word width) and returns read data in the same cycle. It holds a word-addressed data RAM with byte-store (SB) support and a small memory-mapped register file. That register file contains a free-running timer with compare match and interrupt, plus an 8-bit output port.

## Interface
- RAM_WORDS, 64, data RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1
- MMIO_BASE, 32'hFFFF_0000, base of the register window, which decodes on a[31:5] == MMIO_BASE[31:5]

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all MMIO state, does not clear RAM
- memwrite  input  1  write strobe from the core
- memwidth  input  1  1 = byte store (SB), 0 = word store
- a  input  32  byte address (core aluout)
- wd  input  32  write data (core writedata)
- rd  output  32  read data to the core (readdata); combinational
- gpio_out  output  8  output port register
- irq  output  1  timer interrupt, level

## Operation
- **Reads**
  - rd is a pure function of a and current state, valid in the same cycle.
  - rd always returns the full word; a[1:0] is ignored for reads.
  - Unmapped addresses return 0.
  - RAM addresses beyond RAM_WORDS return 0.
- **RAM writes** (memwrite=1, address in RAM range)
  - Word store (memwidth=0): writes wd to word a[31:2].
  - Byte store (memwidth=1): writes wd[7:0] to the lane selected by a[1:0]: 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]. Other lanes are unchanged.
  - Out-of-range RAM writes are ignored.
  - RAM contents are undefined after reset.
- **MMIO registers** (offset a[4:0])
  - Byte stores to the MMIO window are ignored.
  - Misaligned word stores (a[1:0]≠0) to the MMIO window are ignored.
  - 0x00 COUNT: 32-bit, R/W.
  - 0x04 COMPARE: 32-bit, R/W.
  - 0x08 CTRL: R/W.
    - bit0 EN: count enable.
    - bit1 AUTO: reload count to 0 on match.
    - bit2 IE: interrupt enable.
    - Reads return {29'b0, CTRL}.
  - 0x0C STATUS: bit0 MATCH, sticky.
    - A write with wd[0]=1 clears MATCH.
    - Reads return {31'b0, MATCH}.
  - 0x10 GPIO: 8-bit, R/W; drives gpio_out directly; reads return zero-extended value.
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- **Timer**
  - When EN=1, each clock:
    - If COUNT==COMPARE: MATCH←1, and COUNT←(AUTO ? 0 : COUNT+1).
    - Otherwise: COUNT←COUNT+1.
    - The increment wraps modulo 2^32.
  - When EN=0, COUNT holds and no match is detected.
- irq = MATCH & IE, combinational from registers.
- **Precedence on the same edge**
  - A CPU write to COUNT overrides increment/reload.
  - A match still sets MATCH if COUNT==COMPARE was true before the edge.
  - A match set overrides a STATUS clear.
  - A CPU write to CTRL takes effect from the next edge; the current edge uses the old EN/AUTO.

## Timing
- **Reset values:** COUNT=0, COMPARE=32'hFFFF_FFFF, CTRL=0, MATCH=0, GPIO=0.
- **Outputs during reset:** gpio_out=0 and irq=0. rd reflects the reset values of the registers and the undefined RAM contents.
- **Write latency:** a write is visible on rd in the cycle after the edge that commits it.
- **Reset mid-operation:** asserting reset clears MMIO state immediately, without waiting for clk. A write strobed in the same cycle is lost for the MMIO registers. RAM may or may not capture that write.
- **MATCH timing:** MATCH rises on the edge at which COUNT==COMPARE was observed. irq follows in the same cycle as MATCH, given IE=1.
- **No handshake:** the block never stalls the core.

## Test plan
- **Word then byte store:** sw 32'h1122_3344 @0x10, then sb wd=32'hAA @0x12 → rd@0x10 = 32'h11AA_3344. Read @0x13 also returns the full word.
- **Out-of-range RAM:** sw @4*RAM_WORDS → ignored; rd there = 0. RAM words 0 and RAM_WORDS-1 are unaffected.
- **Free-run with auto-reload:** COMPARE=3, CTRL=3'b011 → COUNT reads 0,1,2,3,0,1…. MATCH=1 from the edge after COUNT=3 is observed. irq stays 0 until CTRL=3'b111, then irq=1.
- **Precedence and clear:**
  - With EN=1 and COUNT==COMPARE, write COUNT=32'h50 on the match edge → COUNT=32'h50 and MATCH=1.
  - Write STATUS=1 on a cycle with no match → MATCH=0 and irq=0 next cycle.
  - Write STATUS=1 on a match cycle → MATCH stays 1.
- **Wrap and MMIO filtering:**
  - COUNT=32'hFFFF_FFFF, COMPARE=5, EN=1, AUTO=0 → next COUNT=0.
  - sb to GPIO @MMIO_BASE+0x10 → gpio_out unchanged.
  - sw 32'h1A5 → gpio_out=8'hA5.
  - Unmapped offset 0x18 reads 0.
- **Async reset mid-run:** with the timer running, GPIO=8'h3C, and MATCH=1, pulse reset between clock edges → gpio_out=0, irq=0, COUNT=0 immediately. Previously stored RAM data is still readable after reset.

Source files
------------

// File: rtl/dmem_mmio_if.sv
// Data-bus bundle between the single-cycle core and its data memory.
//   memwrite : write strobe from the core
//   memwidth : 1 = byte store, 0 = word store
//   a        : byte address
//   wd       : write data
//   rd       : read data returned in the same cycle
// The core side uses the master modport; the memory side uses the slave modport.
interface dmem_mmio_if;
    logic        memwrite;
    logic        memwidth;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (
        output memwrite,
        output memwidth,
        output a,
        output wd,
        input  rd
    );

    modport slave (
        input  memwrite,
        input  memwidth,
        input  a,
        input  wd,
        output rd
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem for the single-cycle MIPS core.
// Holds a word-addressed data RAM with byte-store support and a small
// memory-mapped register window: a free-running timer with compare match
// and a level interrupt, plus an 8-bit output port.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous active-high; clears MMIO state, leaves RAM alone
//   bus      : data bus (slave side); rd is combinational from a and state
//   gpio_out : output port register
//   irq      : timer interrupt, MATCH & IE
module dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            reset,
    dmem_mmio_if.slave      bus,
    output logic [7:0]      gpio_out,
    output logic            irq
);

    localparam int         AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [29:0] RAM_LIMIT = 30'(RAM_WORDS);

    // Register offsets within the window, as word index a[4:2]
    localparam logic [2:0] OFS_COUNT   = 3'd0;
    localparam logic [2:0] OFS_COMPARE = 3'd1;
    localparam logic [2:0] OFS_CTRL    = 3'd2;
    localparam logic [2:0] OFS_STATUS  = 3'd3;
    localparam logic [2:0] OFS_GPIO    = 3'd4;

    logic [31:0]   ram [RAM_WORDS];

    logic [31:0]   count_r;
    logic [31:0]   compare_r;
    logic [2:0]    ctrl_r;       // {IE, AUTO, EN}
    logic          match_r;
    logic [7:0]    gpio_r;

    logic [29:0]   word_idx_s;
    logic [AW-1:0] ram_idx_s;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic          mmio_wr_s;
    logic          wr_count_s;
    logic          wr_compare_s;
    logic          wr_ctrl_s;
    logic          wr_status_s;
    logic          wr_gpio_s;
    logic          match_s;
    logic [31:0]   count_next_s;
    logic          match_next_s;
    logic [31:0]   rd_s;

    assign word_idx_s = bus.a[31:2];
    assign ram_idx_s  = word_idx_s[AW-1:0];
    assign ram_hit_s  = (word_idx_s < RAM_LIMIT);
    assign mmio_hit_s = (bus.a[31:5] == MMIO_BASE[31:5]);

    // Only aligned word stores reach the register window.
    assign mmio_wr_s  = bus.memwrite & mmio_hit_s & ~bus.memwidth & (bus.a[1:0] == 2'b00);

    // Per-register write strobes
    always_comb begin
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_ctrl_s    = 1'b0;
        wr_status_s  = 1'b0;
        wr_gpio_s    = 1'b0;
        if (mmio_wr_s) begin
            case (bus.a[4:2])
                OFS_COUNT:   wr_count_s   = 1'b1;
                OFS_COMPARE: wr_compare_s = 1'b1;
                OFS_CTRL:    wr_ctrl_s    = 1'b1;
                OFS_STATUS:  wr_status_s  = 1'b1;
                OFS_GPIO:    wr_gpio_s    = 1'b1;
                default:     wr_gpio_s    = 1'b0;
            endcase
        end else begin
            wr_gpio_s = 1'b0;
        end
    end

    // Timer next state; uses the CTRL value from before this edge
    always_comb begin
        match_s      = ctrl_r[0] & (count_r == compare_r);
        count_next_s = count_r;
        if (wr_count_s) begin
            count_next_s = bus.wd;
        end else if (ctrl_r[0]) begin
            if (match_s && ctrl_r[1]) begin
                count_next_s = 32'd0;
            end else begin
                count_next_s = count_r + 32'd1;
            end
        end else begin
            count_next_s = count_r;
        end

        // A match on this edge wins over a software clear.
        if (match_s) begin
            match_next_s = 1'b1;
        end else if (wr_status_s && bus.wd[0]) begin
            match_next_s = 1'b0;
        end else begin
            match_next_s = match_r;
        end
    end

    // MMIO register state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            ctrl_r    <= 3'b000;
            match_r   <= 1'b0;
            gpio_r    <= 8'h00;
        end else begin
            count_r <= count_next_s;
            match_r <= match_next_s;
            if (wr_compare_s) compare_r <= bus.wd;
            if (wr_ctrl_s)    ctrl_r    <= bus.wd[2:0];
            if (wr_gpio_s)    gpio_r    <= bus.wd[7:0];
        end
    end

    // Data RAM write port; contents are not reset
    always_ff @(posedge clk) begin
        if (bus.memwrite && ram_hit_s) begin
            if (bus.memwidth) begin
                case (bus.a[1:0])
                    2'd0:    ram[ram_idx_s][7:0]   <= bus.wd[7:0];
                    2'd1:    ram[ram_idx_s][15:8]  <= bus.wd[7:0];
                    2'd2:    ram[ram_idx_s][23:16] <= bus.wd[7:0];
                    2'd3:    ram[ram_idx_s][31:24] <= bus.wd[7:0];
                    default: ram[ram_idx_s][7:0]   <= bus.wd[7:0];
                endcase
            end else begin
                ram[ram_idx_s] <= bus.wd;
            end
        end
    end

    // Read mux: full word always, a[1:0] ignored, unmapped reads return 0
    always_comb begin
        rd_s = 32'd0;
        if (ram_hit_s) begin
            rd_s = ram[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (bus.a[4:2])
                OFS_COUNT:   rd_s = count_r;
                OFS_COMPARE: rd_s = compare_r;
                OFS_CTRL:    rd_s = {29'd0, ctrl_r};
                OFS_STATUS:  rd_s = {31'd0, match_r};
                OFS_GPIO:    rd_s = {24'd0, gpio_r};
                default:     rd_s = 32'd0;
            endcase
        end else begin
            rd_s = 32'd0;
        end
    end

    assign bus.rd   = rd_s;
    assign gpio_out = gpio_r;
    assign irq      = match_r & ctrl_r[2];

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

    localparam logic [31:0] MB       = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT  = MB + 32'h00;
    localparam logic [31:0] A_CMP    = MB + 32'h04;
    localparam logic [31:0] A_CTRL   = MB + 32'h08;
    localparam logic [31:0] A_STATUS = MB + 32'h0C;
    localparam logic [31:0] A_GPIO   = MB + 32'h10;

    logic       clk;
    logic       reset;
    logic [7:0] gpio_out;
    logic       irq;

    dmem_mmio_if bus ();

    dmem_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic        wid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus write committed on the next rising edge; returns at edge+1
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic byte_st);
        @(negedge clk);
        bus.a        = addr;
        bus.wd       = data;
        bus.memwidth = byte_st;
        bus.memwrite = 1'b1;
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        bus.memwidth = 1'b0;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        bus.a = addr;
        #1;
        data = bus.rd;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    logic [31:0] exp_cnt [6];
    int          waited;

    initial begin
        bus.memwrite = 1'b0;
        bus.memwidth = 1'b0;
        bus.a        = 32'd0;
        bus.wd       = 32'd0;
        reset        = 1'b1;

        // --- reset state ---
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio", {24'd0, gpio_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        peek(A_COUNT, r);  chk("rst_count", r, 32'd0);
        peek(A_CMP, r);    chk("rst_compare", r, 32'hFFFF_FFFF);
        peek(A_CTRL, r);   chk("rst_ctrl", r, 32'd0);
        peek(A_STATUS, r); chk("rst_status", r, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // --- table-driven RAM and MMIO decode vectors ---
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h1122_3344, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0012, 32'h0000_00AA, 32'h11AA_3344, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h11AA_3344, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0055, 32'h55AD_BEEF, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_1234, 32'h55AD_BE34, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0101, 32'h0000_0077, 32'h0000_0000, 8'h00};
        vecs[11] = '{1'b1, 1'b0, A_GPIO,        32'h0000_01A5, 32'h0000_00A5, 8'hA5};
        vecs[12] = '{1'b1, 1'b1, A_GPIO,        32'h0000_0077, 32'h0000_00A5, 8'hA5};
        vecs[13] = '{1'b1, 1'b0, MB + 32'h11,   32'h0000_0066, 32'h0000_00A5, 8'hA5};
        vecs[14] = '{1'b0, 1'b0, MB + 32'h18,   32'h0000_0000, 32'h0000_0000, 8'hA5};
        vecs[15] = '{1'b1, 1'b0, MB + 32'h18,   32'hFFFF_FFFF, 32'h0000_0000, 8'hA5};
        vecs[16] = '{1'b1, 1'b0, MB + 32'h20,   32'hFFFF_FFFF, 32'h0000_0000, 8'hA5};
        vecs[17] = '{1'b0, 1'b0, A_CMP,         32'h0000_0000, 32'hFFFF_FFFF, 8'hA5};
        vecs[18] = '{1'b1, 1'b0, A_CTRL,        32'hFFFF_FFF8, 32'h0000_0000, 8'hA5};
        vecs[19] = '{1'b1, 1'b0, A_CMP,         32'h0000_0003, 32'h0000_0003, 8'hA5};
        vecs[20] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h11AA_3344, 8'hA5};

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, vecs[i].wid);
            else            idle();
            peek(vecs[i].addr, r);
            chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
            chk($sformatf("vec%0d_gpio", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_gpio});
        end

        // --- free-run with auto-reload, COMPARE=3 ---
        wr(A_COUNT, 32'd0, 1'b0);
        wr(A_CTRL, 32'd3, 1'b0);
        exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        for (int k = 0; k < 6; k++) begin
            peek(A_COUNT, r);
            chk($sformatf("auto_count%0d", k), r, exp_cnt[k]);
            peek(A_STATUS, r);
            chk($sformatf("auto_match%0d", k), r, (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("auto_irq%0d", k), {31'd0, irq}, 32'd0);
            idle();
        end
        wr(A_CTRL, 32'd7, 1'b0);
        chk("ie_irq_on", {31'd0, irq}, 32'd1);

        // --- clear and precedence ---
        wr(A_CTRL, 32'd4, 1'b0);
        chk("stopped_irq", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'd1, 1'b0);
        peek(A_STATUS, r);
        chk("clear_status", r, 32'd0);
        chk("clear_irq", {31'd0, irq}, 32'd0);
        wr(A_COUNT, 32'h10, 1'b0);
        wr(A_CMP, 32'h10, 1'b0);
        peek(A_STATUS, r);
        chk("no_match_when_disabled", r, 32'd0);
        wr(A_CTRL, 32'd5, 1'b0);
        peek(A_COUNT, r);
        chk("ctrl_write_next_edge", r, 32'h10);
        wr(A_COUNT, 32'h50, 1'b0);
        peek(A_COUNT, r);
        chk("count_write_wins", r, 32'h50);
        peek(A_STATUS, r);
        chk("match_on_write_edge", r, 32'd1);
        chk("match_irq", {31'd0, irq}, 32'd1);
        wr(A_CMP, 32'h51, 1'b0);
        wr(A_STATUS, 32'd1, 1'b0);
        peek(A_STATUS, r);
        chk("match_beats_clear", r, 32'd1);
        peek(A_COUNT, r);
        chk("count_after_match", r, 32'h52);

        // --- wrap with AUTO=0 ---
        wr(A_CTRL, 32'd0, 1'b0);
        wr(A_COUNT, 32'hFFFF_FFFF, 1'b0);
        wr(A_CMP, 32'd5, 1'b0);
        wr(A_CTRL, 32'd1, 1'b0);
        peek(A_COUNT, r);
        chk("wrap_before", r, 32'hFFFF_FFFF);
        idle();
        peek(A_COUNT, r);
        chk("wrap_after", r, 32'd0);

        // --- async reset mid-run ---
        wr(A_GPIO, 32'h3C, 1'b0);
        wr(A_CTRL, 32'd5, 1'b0);
        waited = 0;
        while (irq !== 1'b1 && waited < 20) begin
            idle();
            waited++;
        end
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);
        chk("pre_reset_gpio", {24'd0, gpio_out}, 32'h3C);
        repeat (3) idle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_gpio", {24'd0, gpio_out}, 32'd0);
        chk("async_irq", {31'd0, irq}, 32'd0);
        peek(A_COUNT, r);
        chk("async_count", r, 32'd0);
        reset = 1'b0;
        idle();
        peek(A_CMP, r);
        chk("post_reset_compare", r, 32'hFFFF_FFFF);
        peek(A_CTRL, r);
        chk("post_reset_ctrl", r, 32'd0);
        peek(32'h0000_0000, r);
        chk("ram_keeps_word0", r, 32'h55AD_BE34);
        peek(32'h0000_0010, r);
        chk("ram_keeps_word4", r, 32'h11AA_3344);
        peek(32'h0000_00FC, r);
        chk("ram_keeps_last", r, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
